// File: rtl/id_ex_if.sv
// id_ex_if: bundle between the decode stage / control unit and the ID/EX
// pipeline register.
//   master : decode side; drives the *_d control word, operands, indices and
//            the EX redirect flush_e; observes the *_e copies, valid_e,
//            stall_d and bubble_cnt.
//   slave  : the id_ex_stage register itself.
//
// Handshake: stall_d is a combinational "hold" request in the same cycle.
// While stall_d=1 the master must keep every *_d input (and its PC / IF/ID
// register) unchanged; the register inserts a bubble on that edge and captures
// the held instruction on the next edge.
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic [6:0]      opcode_d;
    logic            regwrite_d, luisrc_d, alusrc_d, memwrite_d;
    logic            memread_d, jumppc_d, jumpcontrol_d, bne_d;
    logic [3:0]      aluop_d;
    logic [1:0]      memtoreg_d;
    logic [XLEN-1:0] pc_d, rd1_d, rd2_d, imm_d;
    logic [REGW-1:0] rs1_d, rs2_d, rd_d;
    logic            flush_e;

    logic            regwrite_e, luisrc_e, alusrc_e, memwrite_e;
    logic            memread_e, jumppc_e, jumpcontrol_e, bne_e;
    logic [3:0]      aluop_e;
    logic [1:0]      memtoreg_e;
    logic [XLEN-1:0] pc_e, rd1_e, rd2_e, imm_e;
    logic [REGW-1:0] rs1_e, rs2_e, rd_e;
    logic            valid_e;
    logic            stall_d;
    logic [CNTW-1:0] bubble_cnt;

    modport master (
        output opcode_d, regwrite_d, luisrc_d, alusrc_d, memwrite_d, memread_d,
               jumppc_d, jumpcontrol_d, bne_d, aluop_d, memtoreg_d,
               pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, flush_e,
        input  regwrite_e, luisrc_e, alusrc_e, memwrite_e, memread_e,
               jumppc_e, jumpcontrol_e, bne_e, aluop_e, memtoreg_e,
               pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
               valid_e, stall_d, bubble_cnt
    );

    modport slave (
        input  opcode_d, regwrite_d, luisrc_d, alusrc_d, memwrite_d, memread_d,
               jumppc_d, jumpcontrol_d, bne_d, aluop_d, memtoreg_d,
               pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, flush_e,
        output regwrite_e, luisrc_e, alusrc_e, memwrite_e, memread_e,
               jumppc_e, jumpcontrol_e, bne_e, aluop_e, memtoreg_e,
               pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
               valid_e, stall_d, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use hazard
// detection, bubble insertion on hazard or EX flush, and a saturating count
// of inserted bubbles.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; loads the bubble word, clears the count
//   bus   - id_ex_if.slave: *_d inputs and flush_e in; registered *_e copies,
//           valid_e (FSM state: 0=EMPTY, 1=FULL), combinational stall_d and
//           bubble_cnt out
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic            regwrite;
        logic [3:0]      aluop;
        logic            luisrc;
        logic            alusrc;
        logic            memwrite;
        logic            memread;
        logic [1:0]      memtoreg;
        logic            jumppc;
        logic            jumpcontrol;
        logic            bne;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } ex_word_t;

    state_t          state_q, state_d;
    ex_word_t        ex_q, ex_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    ex_word_t bubble_w;
    ex_word_t capture_w;
    logic     uses_rs1, uses_rs2, haz;

    always_comb begin
        bubble_w        = '0;
        bubble_w.aluop  = 4'b0010;
        bubble_w.luisrc = 1'b1;
        bubble_w.alusrc = 1'b1;

        capture_w.regwrite    = bus.regwrite_d;
        capture_w.aluop       = bus.aluop_d;
        capture_w.luisrc      = bus.luisrc_d;
        capture_w.alusrc      = bus.alusrc_d;
        capture_w.memwrite    = bus.memwrite_d;
        capture_w.memread     = bus.memread_d;
        capture_w.memtoreg    = bus.memtoreg_d;
        capture_w.jumppc      = bus.jumppc_d;
        capture_w.jumpcontrol = bus.jumpcontrol_d;
        capture_w.bne         = bus.bne_d;
        capture_w.pc          = bus.pc_d;
        capture_w.rd1         = bus.rd1_d;
        capture_w.rd2         = bus.rd2_d;
        capture_w.imm         = bus.imm_d;
        capture_w.rs1         = bus.rs1_d;
        capture_w.rs2         = bus.rs2_d;
        capture_w.rd          = bus.rd_d;
    end

    // Operand use. lui/jal have no rs1; the all-zero control-unit default
    // opcode is a nop and reads neither register. rs2 is read only by
    // R-type, stores and branches.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (bus.opcode_d)
            7'b0110111, 7'b1101111, 7'b0000000: uses_rs1 = 1'b0;
            default:                            uses_rs1 = 1'b1;
        endcase
        case (bus.opcode_d)
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default:                            uses_rs2 = 1'b0;
        endcase
    end

    always_comb begin
        haz = (state_q == FULL) && ex_q.memread && (ex_q.rd != '0) &&
              ((uses_rs1 && (bus.rs1_d == ex_q.rd)) ||
               (uses_rs2 && (bus.rs2_d == ex_q.rd)));
        // A redirect discards the decode instruction anyway, so never hold it.
        bus.stall_d = haz && !bus.flush_e;
    end

    // Next state: flush and hazard both squash to a single bubble.
    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        cnt_d   = cnt_q;
        if (bus.flush_e || haz) begin
            state_d = EMPTY;
            ex_d    = bubble_w;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else begin
            state_d = FULL;
            ex_d    = capture_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ex_q    <= bubble_w;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_e       = (state_q == FULL);
    assign bus.bubble_cnt    = cnt_q;
    assign bus.regwrite_e    = ex_q.regwrite;
    assign bus.aluop_e       = ex_q.aluop;
    assign bus.luisrc_e      = ex_q.luisrc;
    assign bus.alusrc_e      = ex_q.alusrc;
    assign bus.memwrite_e    = ex_q.memwrite;
    assign bus.memread_e     = ex_q.memread;
    assign bus.memtoreg_e    = ex_q.memtoreg;
    assign bus.jumppc_e      = ex_q.jumppc;
    assign bus.jumpcontrol_e = ex_q.jumpcontrol;
    assign bus.bne_e         = ex_q.bne;
    assign bus.pc_e          = ex_q.pc;
    assign bus.rd1_e         = ex_q.rd1;
    assign bus.rd2_e         = ex_q.rd2;
    assign bus.imm_e         = ex_q.imm;
    assign bus.rs1_e         = ex_q.rs1;
    assign bus.rs2_e         = ex_q.rs2;
    assign bus.rd_e          = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  typedef struct packed {
    logic        regwrite;
    logic [3:0]  aluop;
    logic        luisrc, alusrc, memwrite, memread;
    logic [1:0]  memtoreg;
    logic        jumppc, jumpcontrol, bne;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
  } ex_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(32), .REGW(5), .CNTW(16)) bus ();
  id_ex_if #(.XLEN(32), .REGW(5), .CNTW(4))  bus4 ();

  id_ex_stage #(.XLEN(32), .REGW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  id_ex_stage #(.XLEN(32), .REGW(5), .CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_pass   = 0;
  ex_t  m_ex;          // what EX should hold
  int   m_cnt;         // unbounded bubble count since reset
  logic last_stall;
  logic stall_seen;
  logic [6:0] ops[10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUI, OP_NOP};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b = '0;
    b.aluop  = 4'b0010;
    b.luisrc = 1'b1;
    b.alusrc = 1'b1;
    return b;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_JAL || op == OP_NOP);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_ST || op == OP_BR);
  endfunction

  function automatic logic [15:0] sat(input int v, input int maxv);
    return (v > maxv) ? 16'(maxv) : 16'(v);
  endfunction

  function automatic ex_t obs_ex();
    ex_t o;
    o.regwrite = bus.regwrite_e;   o.aluop = bus.aluop_e;
    o.luisrc = bus.luisrc_e;       o.alusrc = bus.alusrc_e;
    o.memwrite = bus.memwrite_e;   o.memread = bus.memread_e;
    o.memtoreg = bus.memtoreg_e;   o.jumppc = bus.jumppc_e;
    o.jumpcontrol = bus.jumpcontrol_e; o.bne = bus.bne_e;
    o.pc = bus.pc_e;   o.rd1 = bus.rd1_e;  o.rd2 = bus.rd2_e;  o.imm = bus.imm_e;
    o.rs1 = bus.rs1_e; o.rs2 = bus.rs2_e;  o.rd = bus.rd_e;    o.valid = bus.valid_e;
    return o;
  endfunction

  // Directed instruction with control bits a simple control unit would give.
  function automatic ex_t mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                             input logic [31:0] a, b, input logic [3:0] aluop);
    ex_t w;
    w = '0;
    w.regwrite = !(op == OP_ST || op == OP_BR);
    w.memread  = (op == OP_LD);
    w.memwrite = (op == OP_ST);
    w.alusrc   = (op == OP_I || op == OP_LD || op == OP_ST);
    w.memtoreg = (op == OP_LD) ? 2'b01 : 2'b00;
    w.bne      = (op == OP_BR);
    w.aluop    = aluop;
    w.pc = $urandom; w.imm = $urandom;
    w.rd1 = a; w.rd2 = b;
    w.rs1 = rs1; w.rs2 = rs2; w.rd = rd;
    return w;
  endfunction

  task automatic rand_instr(output logic [6:0] op, output ex_t w);
    op = ops[$urandom_range(0, 9)];
    w = ex_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    w.memread = ($urandom_range(0, 1) == 1);
    w.rs1 = 5'($urandom_range(0, 3));
    w.rs2 = 5'($urandom_range(0, 3));
    w.rd  = 5'($urandom_range(0, 3));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [6:0] op, input ex_t w, input logic fl);
    bus.opcode_d = op;  bus4.opcode_d = op;
    bus.regwrite_d = w.regwrite;  bus4.regwrite_d = w.regwrite;
    bus.aluop_d = w.aluop;        bus4.aluop_d = w.aluop;
    bus.luisrc_d = w.luisrc;      bus4.luisrc_d = w.luisrc;
    bus.alusrc_d = w.alusrc;      bus4.alusrc_d = w.alusrc;
    bus.memwrite_d = w.memwrite;  bus4.memwrite_d = w.memwrite;
    bus.memread_d = w.memread;    bus4.memread_d = w.memread;
    bus.memtoreg_d = w.memtoreg;  bus4.memtoreg_d = w.memtoreg;
    bus.jumppc_d = w.jumppc;      bus4.jumppc_d = w.jumppc;
    bus.jumpcontrol_d = w.jumpcontrol; bus4.jumpcontrol_d = w.jumpcontrol;
    bus.bne_d = w.bne;            bus4.bne_d = w.bne;
    bus.pc_d = w.pc;              bus4.pc_d = w.pc;
    bus.rd1_d = w.rd1;            bus4.rd1_d = w.rd1;
    bus.rd2_d = w.rd2;            bus4.rd2_d = w.rd2;
    bus.imm_d = w.imm;            bus4.imm_d = w.imm;
    bus.rs1_d = w.rs1;            bus4.rs1_d = w.rs1;
    bus.rs2_d = w.rs2;            bus4.rs2_d = w.rs2;
    bus.rd_d = w.rd;              bus4.rd_d = w.rd;
    bus.flush_e = fl;             bus4.flush_e = fl;
  endtask

  // One cycle: drive, check stall mid-cycle, clock, update model, check EX.
  task automatic step(input logic rst, input logic fl, input logic [6:0] op,
                      input ex_t w, output logic stall_obs);
    logic exp_haz, exp_stall;
    reset = rst;
    drive(op, w, fl);
    exp_haz = m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) &&
              ((reads_rs1(op) && w.rs1 == m_ex.rd) ||
               (reads_rs2(op) && w.rs2 == m_ex.rd));
    exp_stall = exp_haz && !fl;
    @(negedge clk);
    stall_obs = bus.stall_d;
    chk("stall_d", 160'(bus.stall_d), 160'(exp_stall));
    chk("stall_d_c4", 160'(bus4.stall_d), 160'(exp_stall));
    @(posedge clk);
    if (rst) begin
      m_ex = bubble();
      m_cnt = 0;
    end else if (fl || exp_haz) begin
      m_ex = bubble();
      m_cnt++;
    end else begin
      m_ex = w;
      m_ex.valid = 1'b1;
    end
    last_stall = exp_stall;
    #1;
    chk("ex_word", 160'(obs_ex()), 160'(m_ex));
    chk("bubble_cnt", 160'(bus.bubble_cnt), 160'(sat(m_cnt, 65535)));
    chk("bubble_cnt_c4", 160'(bus4.bubble_cnt), 160'(sat(m_cnt, 15)));
    chk("valid_e_c4", 160'(bus4.valid_e), 160'(m_ex.valid));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [6:0] op;
    ex_t w, add7;
    int cnt_before;

    rand_instr(op, w);
    reset = 1'b1;
    drive(op, w, 1'b0);
    @(posedge clk);
    #1;
    m_ex = bubble();
    m_cnt = 0;
    last_stall = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      rand_instr(op, w);
      step(1'b1, $urandom_range(0, 1) == 1, op, w, stall_seen);
    end
    chk("rst_aluop_e", 160'(bus.aluop_e), 160'(4'b0010));
    chk("rst_luisrc_e", 160'(bus.luisrc_e), 160'(1'b1));
    chk("rst_valid_e", 160'(bus.valid_e), 160'(1'b0));
    chk("rst_bubble_cnt", 160'(bus.bubble_cnt), 160'(16'd0));

    // Pass-through add
    w = mk(OP_R, 5'd5, 5'd1, 5'd2, 32'h10, 32'h20, 4'b0110);
    step(1'b0, 1'b0, OP_R, w, stall_seen);
    chk("add_valid_e", 160'(bus.valid_e), 160'(1'b1));
    chk("add_regwrite_e", 160'(bus.regwrite_e), 160'(1'b1));
    chk("add_rd_e", 160'(bus.rd_e), 160'(5'd5));
    chk("add_rd2_e", 160'(bus.rd2_e), 160'(32'h20));

    // Load-use: one stall, one bubble, then the add proceeds
    step(1'b0, 1'b0, OP_LD, mk(OP_LD, 5'd7, 5'd1, 5'd0, 0, 0, 4'b0010), stall_seen);
    add7 = mk(OP_R, 5'd8, 5'd7, 5'd2, 32'h3, 32'h4, 4'b0110);
    step(1'b0, 1'b0, OP_R, add7, stall_seen);
    chk("lu_stall", 160'(stall_seen), 160'(1'b1));
    chk("lu_bubble_valid", 160'(bus.valid_e), 160'(1'b0));
    chk("lu_bubble_cnt", 160'(bus.bubble_cnt), 160'(16'd1));
    step(1'b0, 1'b0, OP_R, add7, stall_seen);
    chk("lu_resume_stall", 160'(stall_seen), 160'(1'b0));
    chk("lu_resume_rd_e", 160'(bus.rd_e), 160'(5'd8));

    // No false stalls
    step(1'b0, 1'b0, OP_LD, mk(OP_LD, 5'd0, 5'd1, 5'd0, 0, 0, 4'b0010), stall_seen);
    step(1'b0, 1'b0, OP_R, mk(OP_R, 5'd4, 5'd0, 5'd0, 0, 0, 4'b0110), stall_seen);
    chk("nfs_rd0", 160'(stall_seen), 160'(1'b0));
    step(1'b0, 1'b0, OP_LD, mk(OP_LD, 5'd7, 5'd1, 5'd0, 0, 0, 4'b0010), stall_seen);
    step(1'b0, 1'b0, OP_I, mk(OP_I, 5'd4, 5'd3, 5'd7, 0, 0, 4'b0010), stall_seen);
    chk("nfs_addi_rs2", 160'(stall_seen), 160'(1'b0));
    step(1'b0, 1'b0, OP_LD, mk(OP_LD, 5'd7, 5'd1, 5'd0, 0, 0, 4'b0010), stall_seen);
    step(1'b0, 1'b0, OP_LUI, mk(OP_LUI, 5'd4, 5'd7, 5'd0, 0, 0, 4'b0000), stall_seen);
    chk("nfs_lui_rs1", 160'(stall_seen), 160'(1'b0));

    // Flush coinciding with a hazard: one bubble, no stall
    step(1'b0, 1'b0, OP_LD, mk(OP_LD, 5'd9, 5'd1, 5'd0, 0, 0, 4'b0010), stall_seen);
    cnt_before = int'(bus.bubble_cnt);
    step(1'b0, 1'b1, OP_ST, mk(OP_ST, 5'd0, 5'd1, 5'd9, 0, 0, 4'b0010), stall_seen);
    chk("fh_stall", 160'(stall_seen), 160'(1'b0));
    chk("fh_valid_e", 160'(bus.valid_e), 160'(1'b0));
    chk("fh_cnt_plus1", 160'(bus.bubble_cnt), 160'(16'(cnt_before + 1)));

    // Saturation of the 4-bit counter, then reset mid-stream
    for (int i = 0; i < 20; i++) begin
      rand_instr(op, w);
      step(1'b0, 1'b1, op, w, stall_seen);
    end
    chk("sat_c4", 160'(bus4.bubble_cnt), 160'(4'hF));
    rand_instr(op, w);
    step(1'b1, 1'b1, op, w, stall_seen);
    chk("sat_reset_c4", 160'(bus4.bubble_cnt), 160'(4'h0));

    // Randomized traffic; upstream honours stall_d by holding its inputs
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) rand_instr(op, w);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0, op, w, stall_seen);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the five-stage RISC-V core, sitting directly downstream of the control unit. It latches the decode-stage control word and operands into execute-stage copies every cycle. It also detects load-use hazards, stalls fetch/decode, and inserts bubbles. Execute-stage flushes (taken `bne`, `jal`, `jalr`) squash the instruction in flight, and a saturating counter records how many bubbles were inserted.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register-index width
- `CNTW`, 16, bubble-counter width

Ports:
- `clk` in 1: rising-edge clock; one clock.
- `reset` in 1: synchronous, active-high.
- `opcode_d` in 7: decode-stage opcode, used for operand-use decode.
- `regwrite_d, luisrc_d, alusrc_d, memwrite_d, memread_d, jumppc_d, jumpcontrol_d, bne_d` in 1 each: control-unit outputs.
- `aluop_d` in 4, `memtoreg_d` in 2: control-unit outputs.
- `pc_d, rd1_d, rd2_d, imm_d` in XLEN: PC, register-file reads, immediate.
- `rs1_d, rs2_d, rd_d` in REGW: register indices.
- `flush_e` in 1: EX redirect; squash the instruction entering EX.
- Same-named `_e` outputs for every control, data and index input above (registered).
- `valid_e` out 1: EX holds a real instruction.
- `stall_d` out 1: combinational; hold PC and IF/ID register.
- `bubble_cnt` out CNTW: saturating count of inserted bubbles.

## Operation
- Bubble word: `regwrite_e=0`, `aluop_e=4'b0010`, `luisrc_e=1`, `alusrc_e=1`, `memwrite_e=0`, `memread_e=0`, `memtoreg_e=2'b00`, `jumppc_e=0`, `jumpcontrol_e=0`, `bne_e=0`. All data and index outputs are 0, and `valid_e=0`.
- Operand use is decoded from `opcode_d`:
  - `uses_rs1` = 1 except for opcodes 0110111 (lui) and 1101111 (jal).
  - `uses_rs2` = 1 only for opcodes 0110011, 0100011 and 1100011.
  - The nop/default opcode uses neither operand.
- Hazard: `haz = valid_e & memread_e & (rd_e != 0) & ((uses_rs1 & rs1_d == rd_e) | (uses_rs2 & rs2_d == rd_e))`.
- `stall_d = haz & ~flush_e`.
- Register update per edge, in priority order:
  1. `reset`: load the bubble word and clear `bubble_cnt`.
  2. `flush_e`: load the bubble word and increment `bubble_cnt`.
  3. `haz`: load the bubble word and increment `bubble_cnt`.
  4. Otherwise: capture all `_d` inputs and set `valid_e=1`. The captured instruction may itself be a nop from the control-unit default; it is still treated as valid.
- `bubble_cnt` saturates at all-ones and never wraps.
- State machine, tracked through `valid_e`:
  - States: EMPTY (`valid_e=0`) and FULL (`valid_e=1`).
  - EMPTY→FULL on a normal capture.
  - FULL→EMPTY on flush or hazard.
  - FULL→FULL on a normal capture.
- A load that is stalled against proceeds on the following cycle. By then EX holds a bubble, so `haz=0` and the consumer captures; forwarding from MEM handles the data.

## Timing
- Latency: `_d` inputs appear on `_e` outputs one cycle later. There is no combinational path from `_d` inputs to `_e` outputs.
- `stall_d` is combinational from the current `_e` state plus `opcode_d`, `rs1_d`, `rs2_d` and `flush_e`, valid in the same cycle. Upstream must hold the `_d` inputs while `stall_d=1`.
- A load-use hazard costs exactly one bubble cycle. `stall_d` is high for exactly one cycle per load-use pair.
- Simultaneous `flush_e` and `haz`:
  - A single bubble is inserted and `bubble_cnt` increments once.
  - `stall_d=0`, because upstream is being redirected.
- `reset` asserted mid-operation: the bubble word appears on the next edge regardless of `flush_e` or `haz`. `stall_d` evaluates to 0 after that edge.
- Reset values: all outputs equal the bubble word, `valid_e=0`, `bubble_cnt=0`, and `stall_d=0`.

## Test plan
1. **Reset:** hold `reset` for 2 cycles with random `_d` inputs. Expect `aluop_e=0010`, `luisrc_e=1`, `alusrc_e=1`, all other controls 0, `valid_e=0`, `bubble_cnt=0`, `stall_d=0`.
2. **Pass-through:** present add (opcode 0110011, `rd_d=5`, `rs1_d=1`, `rs2_d=2`, `rd1_d=0x10`, `rd2_d=0x20`, `aluop_d=0110`). Next cycle expect identical `_e` values, `valid_e=1`, `regwrite_e=1`.
3. **Load-use:**
   - lw `rd=7` is captured; next ID is add with `rs1=7`.
   - Expect `stall_d=1` for one cycle, then a bubble in EX with `bubble_cnt=1`.
   - The following cycle expect the add in EX with `stall_d=0`.
4. **No false stalls:**
   - lw `rd=0` followed by add with `rs1=0`: `stall_d=0`.
   - lw `rd=7` followed by addi (0010011) with `rs2` field = 7 and `rs1=3`: `stall_d=0`.
   - lw `rd=7` followed by lui with `rs1` field = 7: `stall_d=0`.
5. **Flush with hazard:** lw `rd=9` in EX, ID sw with `rs2=9`, `flush_e=1` in the same cycle. Expect `stall_d=0`, a bubble next cycle, and `bubble_cnt` +1 (not +2).
6. **Saturation:** with `CNTW=4`, force 20 consecutive flushes. Expect `bubble_cnt` to stop at 0xF. Then assert `reset` mid-stream and expect 0 on the next edge.
